// File: rtl/nmi_dma_pkg.sv
// nmi_dma_pkg: shared FSM states, register offsets and byte-strobe merge helper
package nmi_dma_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_STAT = 8'h04;
  localparam logic [7:0] OFF_SRC  = 8'h08;
  localparam logic [7:0] OFF_DST  = 8'h0C;
  localparam logic [7:0] OFF_LEN  = 8'h10;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/nmi_if.sv
// nmi_if: valid/ready NMI bus, a beat is a write when wstrb is non-zero
interface nmi_if #(parameter int ADDR_WIDTH = 32) ();
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic [31:0]           rdata;
  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/dffr.sv
// dffr: register cell with asynchronous active-low reset to zero
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= d;
endmodule

// File: rtl/nmi_dma.sv
// nmi_dma: single-channel word copy engine with an NMI register port and completion IRQ
module nmi_dma import nmi_dma_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  nmi_if.slave  cfg,
  nmi_if.master mst,
  output logic  irq_o
);
  state_e                state;
  logic [ADDR_WIDTH-1:0] src_cfg, dst_cfg, src_w, dst_w, maddr_q;
  logic [LEN_WIDTH-1:0]  len_cfg, cnt;
  logic [31:0]           wdata_q, rdata_q, rd_val, wm_src, wm_dst, wm_len;
  logic [3:0]            wstrb_q;
  logic [7:0]            off;
  logic irq_en, done_q, abort_q, mvalid_q, ready_q, irq_q;
  logic cfg_wr, ctrl_wr, start, abort_req, busy, mst_hs, done_d, irq_en_d;
  logic unused_bits;
  assign off       = cfg.addr[7:0];
  assign cfg_wr    = cfg.valid && ready_q && |cfg.wstrb;
  assign ctrl_wr   = cfg_wr && off == OFF_CTRL && cfg.wstrb[0];
  assign start     = ctrl_wr && cfg.wdata[0];
  assign abort_req = ctrl_wr && cfg.wdata[2];
  assign busy      = state == RD || state == WR;
  assign mst_hs    = mvalid_q && mst.ready;
  assign irq_en_d  = ctrl_wr ? cfg.wdata[1] : irq_en;
  // completion set wins over a same-cycle write-1-to-clear
  assign done_d    = state == DONE || (done_q && !(cfg_wr && off == OFF_STAT && cfg.wstrb[0] && cfg.wdata[1]));
  assign wm_src    = strb_merge(32'(src_cfg), cfg.wdata, cfg.wstrb);
  assign wm_dst    = strb_merge(32'(dst_cfg), cfg.wdata, cfg.wstrb);
  assign wm_len    = strb_merge(32'(len_cfg), cfg.wdata, cfg.wstrb);
  assign rd_val    = off == OFF_CTRL ? {30'b0, irq_en, 1'b0} :
                     off == OFF_STAT ? {30'b0, done_q, busy} :
                     off == OFF_SRC  ? 32'(src_cfg) :
                     off == OFF_DST  ? 32'(dst_cfg) :
                     off == OFF_LEN  ? 32'(len_cfg) : '0;
  assign unused_bits = ^{cfg.addr, wm_src[1:0], wm_dst[1:0], wm_len};
  assign cfg.ready = ready_q;
  assign cfg.rdata = rdata_q;
  assign mst.valid = mvalid_q;
  assign mst.addr  = maddr_q;
  assign mst.wdata = wdata_q;
  assign mst.wstrb = wstrb_q;
  assign irq_o     = irq_q;

  dffr #(.W(1)) u_ready (.clk(clk_i), .rst_n(rst_n_i), .d(cfg.valid && !ready_q), .q(ready_q));

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      src_cfg <= '0;
      dst_cfg <= '0;
      len_cfg <= '0;
      irq_en  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdata_q <= (cfg.valid && !ready_q) ? rd_val : '0;
      irq_en  <= irq_en_d;
      done_q  <= done_d;
      irq_q   <= done_d && irq_en_d;
      if (cfg_wr && !busy && off == OFF_SRC) src_cfg <= {wm_src[ADDR_WIDTH-1:2], 2'b00};
      if (cfg_wr && !busy && off == OFF_DST) dst_cfg <= {wm_dst[ADDR_WIDTH-1:2], 2'b00};
      if (cfg_wr && !busy && off == OFF_LEN) len_cfg <= wm_len[LEN_WIDTH-1:0];
    end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state    <= IDLE;
      src_w    <= '0;
      dst_w    <= '0;
      cnt      <= '0;
      maddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      mvalid_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_w    <= src_cfg;
          dst_w    <= dst_cfg;
          cnt      <= len_cfg;
          abort_q  <= 1'b0;
          maddr_q  <= src_cfg;
          wstrb_q  <= '0;
          mvalid_q <= |len_cfg;
          state    <= |len_cfg ? RD : DONE;
        end
        RD: begin
          abort_q <= abort_q || abort_req;
          if (mst_hs && abort_q) begin
            mvalid_q <= 1'b0;
            state    <= DONE;
          end else if (mst_hs) begin
            maddr_q <= dst_w;
            wdata_q <= mst.rdata;
            wstrb_q <= 4'hF;
            state   <= WR;
          end
        end
        WR: begin
          abort_q <= abort_q || abort_req;
          if (mst_hs) begin
            src_w    <= src_w + ADDR_WIDTH'(4);
            dst_w    <= dst_w + ADDR_WIDTH'(4);
            cnt      <= cnt - LEN_WIDTH'(1);
            maddr_q  <= src_w + ADDR_WIDTH'(4);
            wstrb_q  <= '0;
            mvalid_q <= !(cnt == LEN_WIDTH'(1) || abort_q);
            state    <= (cnt == LEN_WIDTH'(1) || abort_q) ? DONE : RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_nmi_dma.sv
// tb_nmi_dma: scoreboard bench for nmi_dma with a backpressuring memory slave
module tb_nmi_dma;
  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} beat_t;
  localparam logic [31:0] CTRL = 32'h00, STAT = 32'h04, SRC = 32'h08, DST = 32'h0C, LEN = 32'h10;
  logic clk = 1'b0;
  logic rst_n;
  logic irq;
  int passed = 0, total = 0, beats = 0, mvc = 0, delay = 0;
  beat_t exp_mst[$];
  logic [31:0] exp_cfg[$];
  logic [31:0] wmem [logic [31:0]];

  nmi_if #(.ADDR_WIDTH(32)) cfg_bus ();
  nmi_if #(.ADDR_WIDTH(32)) mst_bus ();

  nmi_dma #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg(cfg_bus), .mst(mst_bus), .irq_o(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
    else passed++;
  endtask

  task automatic cfg_acc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    cfg_bus.valid = 1'b1; cfg_bus.addr = a; cfg_bus.wdata = d; cfg_bus.wstrb = s;
    @(posedge clk); @(negedge clk);
    chk("cfg_ready", cfg_bus.ready, 1);
    @(posedge clk); #1;
    cfg_bus.valid = 1'b0; cfg_bus.wstrb = 4'h0;
    @(negedge clk);
    chk("cfg_pulse", cfg_bus.ready, 0);
  endtask

  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    cfg_acc(a, d, 4'hF);
  endtask

  task automatic cfg_rd(input logic [31:0] a, input logic [31:0] e);
    exp_cfg.push_back(e);
    cfg_acc(a, 32'h0, 4'h0);
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_mst.push_back('{s + 32'(4*i), 32'h0, 4'h0});
      exp_mst.push_back('{d + 32'(4*i), pat(s + 32'(4*i)), 4'hF});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_mst.size() != 0; i++) @(negedge clk);
    chk("drain", exp_mst.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // memory slave: ready after `delay` waiting cycles, reads return pat(addr)
  initial begin
    int wcnt = 0;
    mst_bus.ready = 1'b0; mst_bus.rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (mst_bus.ready) begin mst_bus.ready = 1'b0; wcnt = 0; end
      if (!mst_bus.valid) wcnt = 0;
      else if (!mst_bus.ready && wcnt >= delay) begin
        mst_bus.ready = 1'b1;
        mst_bus.rdata = pat(mst_bus.addr);
        if (mst_bus.wstrb != 4'h0) wmem[mst_bus.addr] = mst_bus.wdata;
      end else if (!mst_bus.ready) wcnt++;
    end
  end

  // monitor: pops expected beats/readbacks, checks stability under backpressure
  initial begin
    beat_t e;
    logic pv, pr;
    logic [68:0] prev, cur;
    pv = 1'b0; pr = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      cur = {mst_bus.valid, mst_bus.addr, mst_bus.wdata, mst_bus.wstrb};
      if (rst_n) begin
        if (mst_bus.valid) mvc++;
        if (pv && !pr) chk("mst_hold", cur, prev);
        if (mst_bus.valid && mst_bus.ready) begin
          beats++;
          if (exp_mst.size() == 0) chk("mst_unexpected", mst_bus.addr, 32'hDEAD_BEEF);
          else begin
            e = exp_mst.pop_front();
            chk("mst_addr", mst_bus.addr, e.addr);
            chk("mst_wstrb", mst_bus.wstrb, e.strb);
            if (e.strb != 4'h0) chk("mst_wdata", mst_bus.wdata, e.data);
          end
        end
        if (cfg_bus.valid && cfg_bus.ready && cfg_bus.wstrb == 4'h0) begin
          if (exp_cfg.size() == 0) chk("cfg_unexpected", cfg_bus.rdata, 32'hDEAD_BEEF);
          else chk("cfg_rdata", cfg_bus.rdata, exp_cfg.pop_front());
        end
      end
      pv = rst_n && mst_bus.valid;
      pr = mst_bus.ready;
      prev = cur;
    end
  end

  initial begin
    int b0, v0;
    rst_n = 1'b0;
    cfg_bus.valid = 1'b0; cfg_bus.addr = '0; cfg_bus.wdata = '0; cfg_bus.wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", mst_bus.valid, 0);
    chk("rst_mwstrb", mst_bus.wstrb, 0);
    chk("rst_ready", cfg_bus.ready, 0);
    chk("rst_rdata", cfg_bus.rdata, 0);
    chk("rst_irq", irq, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cfg_rd(CTRL, 0); cfg_rd(STAT, 0); cfg_rd(SRC, 0);
    // basic copy, low address bits forced to zero, unmapped offset
    cfg_wr(SRC, 32'h103); cfg_wr(DST, 32'h200); cfg_wr(LEN, 4);
    cfg_rd(SRC, 32'h100); cfg_wr(32'h14, 32'hFFFF); cfg_rd(32'h14, 0);
    push_copy(32'h100, 32'h200, 4);
    b0 = beats;
    cfg_wr(CTRL, 32'h1);
    chk("start_valid", mst_bus.valid, 1);
    chk("start_addr", mst_bus.addr, 32'h100);
    drain();
    chk("basic_beats", beats - b0, 8);
    cfg_rd(STAT, 32'h2);
    chk("basic_irq", irq, 0);
    chk("basic_mem", wmem[32'h20C], pat(32'h10C));
    cfg_wr(STAT, 32'h2); cfg_rd(STAT, 0);
    // zero length with IRQ_EN written alongside START
    cfg_wr(LEN, 0);
    v0 = mvc;
    cfg_wr(CTRL, 32'h3);
    @(negedge clk);
    chk("zl_irq", irq, 1);
    cfg_rd(STAT, 32'h2);
    chk("zl_novalid", mvc - v0, 0);
    cfg_rd(CTRL, 32'h2);
    cfg_wr(STAT, 32'h2);
    chk("w1c_irq", irq, 0);
    cfg_rd(STAT, 0);
    // backpressure
    delay = 5;
    cfg_wr(SRC, 32'h300); cfg_wr(DST, 32'h400); cfg_wr(LEN, 2);
    push_copy(32'h300, 32'h400, 2);
    cfg_wr(CTRL, 32'h3);
    drain();
    cfg_rd(STAT, 32'h2);
    chk("bp_irq", irq, 1);
    chk("bp_mem", wmem[32'h404], pat(32'h304));
    cfg_wr(STAT, 32'h2);
    // abort during third read
    cfg_wr(SRC, 32'h500); cfg_wr(DST, 32'h600); cfg_wr(LEN, 8);
    push_copy(32'h500, 32'h600, 2);
    exp_mst.push_back('{32'h508, 32'h0, 4'h0});
    b0 = beats;
    cfg_wr(CTRL, 32'h3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mst_bus.valid && mst_bus.wstrb == 4'h0 && mst_bus.addr == 32'h508) break;
    end
    chk("abort_rd3", mst_bus.addr, 32'h508);
    cfg_wr(CTRL, 32'h6);
    drain();
    repeat (20) @(posedge clk);
    chk("abort_beats", beats - b0, 5);
    chk("abort_no_wr3", wmem.exists(32'h608), 0);
    cfg_rd(STAT, 32'h2);
    chk("abort_irq", irq, 1);
    cfg_wr(STAT, 32'h2);
    // address wrap and busy write protection
    delay = 3;
    cfg_wr(SRC, 32'hFFFF_FFF8); cfg_wr(DST, 32'h700); cfg_wr(LEN, 3);
    push_copy(32'hFFFF_FFF8, 32'h700, 3);
    cfg_wr(CTRL, 32'h3);
    cfg_wr(SRC, 32'h1234); cfg_wr(LEN, 5);
    cfg_rd(SRC, 32'hFFFF_FFF8); cfg_rd(LEN, 3); cfg_rd(DST, 32'h700);
    drain();
    cfg_rd(STAT, 32'h2);
    chk("wrap_mem", wmem[32'h708], pat(32'h0));
    cfg_wr(STAT, 32'h2);
    // reset mid-transfer
    delay = 5;
    cfg_wr(SRC, 32'h800); cfg_wr(DST, 32'h900); cfg_wr(LEN, 8);
    push_copy(32'h800, 32'h900, 8);
    cfg_wr(CTRL, 32'h3);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_mst.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mrst_mvalid", mst_bus.valid, 0);
    chk("mrst_irq", irq, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    v0 = mvc;
    repeat (10) @(posedge clk);
    chk("mrst_novalid", mvc - v0, 0);
    cfg_rd(STAT, 0); cfg_rd(CTRL, 0); cfg_rd(SRC, 0);
    chk("mrst_irq2", irq, 0);
    chk("cfg_queue", exp_cfg.size(), 0);
    chk("mst_queue", exp_mst.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
